root_child_arbiter: RTL
=======================

Name: root_child_arbiter

Overview:
- Round-robin scheduler that sequences the five child instances of a root module (sf9_0..sf9_4) through one shared resource slot.
- Each child raises a request, receives an exclusive one-hot grant, and signals completion.
- A per-grant watchdog reclaims the slot from a child that never completes.
- Sits directly under the root module, between the child instances and the shared resource.

Parameters:
- NUM_CHILD, 5, number of requesters; grant index width is IDW = $clog2(NUM_CHILD).
- TIMEOUT, 16, maximum GRANT cycles before forced release; must be ≥ 2.
- CW, $clog2(TIMEOUT), width of the watchdog counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_CHILD  per-child request, level-sensitive.
- done  input  NUM_CHILD  per-child completion; only the bit of the granted child is honoured.
- grant  output  NUM_CHILD  one-hot grant, registered.
- grant_id  output  IDW  index of the current or last grantee, registered.
- busy  output  1  high while in GRANT state.
- timeout_pulse  output  1  one-cycle pulse when a grant is forcibly released.
- timeout_id  output  IDW  index of the timed-out child; holds until the next timeout.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, grant_id=0, busy=0, timeout_pulse=0, timeout_id=0.
  - Round-robin pointer ptr=0, counter=0.
  - Reset asserted mid-GRANT drops grant immediately; no timeout_pulse is generated.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit searching ptr, ptr+1, … with modulo-NUM_CHILD wrap.
  - Next cycle: state=GRANT, grant=one-hot(sel), grant_id=sel, busy=1, counter=0.
  - Latency is req asserted at edge E → grant visible after edge E.
- GRANT:
  - Grant is held regardless of req changes; there is no preemption.
  - Dropping req[g] does not release the grant.
  - done[g]=1 → RELEASE.
  - Otherwise, counter==TIMEOUT-1 → RELEASE with timeout_pulse=1 and timeout_id=g, both visible in the first RELEASE cycle.
  - Otherwise counter increments.
  - done[g] and counter==TIMEOUT-1 in the same cycle: done wins, no timeout.
  - done bits of non-granted children are ignored in all states.
- RELEASE (exactly one cycle):
  - grant=0, busy=0.
  - ptr = (g+1) mod NUM_CHILD, wrapping from NUM_CHILD-1 to 0.
  - Next state is IDLE unconditionally.
  - Minimum grant-to-grant gap is 2 zero cycles (RELEASE, IDLE).
- Output rules:
  - grant is always one-hot or zero.
  - grant_id holds its value through RELEASE and IDLE.
  - timeout_pulse is never high for more than one consecutive cycle.
- Fairness: with all requesters continuously asserted, the grant order is 0,1,2,3,4,0,…; no child waits more than NUM_CHILD-1 grants.

Test Plan:
- Reset then req=5'b00100 → grant=5'b00100 one cycle later, grant_id=2, busy=1. Then done[2]=1 → grant=0 next cycle, next grant to 2 (if still requesting) 3 cycles after done.
- req=5'b11111 held, each grantee asserts done on its 3rd grant cycle → grant sequence 0,1,2,3,4,0; never two bits set; 2-cycle gaps.
- req[1]=1, done never asserted, TIMEOUT=16 → grant held exactly 16 cycles. Then timeout_pulse=1 for one cycle, timeout_id=1, and the next grant goes to the next requester after index 1.
- done[1] and the timeout boundary coincide, plus done[3] asserted while 1 is granted → release with timeout_pulse=0; done[3] has no effect.
- Child 4 granted, then req=5'b10001 → after 4's release, 0 is granted (ptr wrapped 4→0).
- rst pulsed while grant=5'b01000 mid-count → grant=0 and busy=0 immediately (async). After release, req=5'b01001 → grant to 0 (ptr reset).

Source files
------------

// File: rtl/root_child_arbiter.sv
// root_child_arbiter
//   Round-robin owner of one shared resource slot for the child instances of
//   the root module. A child raises req, receives an exclusive one-hot grant,
//   and signals done. A watchdog reclaims the slot after TIMEOUT grant cycles.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   req            per-child request (level)
//   done           per-child completion; only the granted child's bit counts
//   grant          registered one-hot grant (or zero)
//   grant_id       index of current / last grantee
//   busy           high while a grant is held
//   timeout_pulse  one-cycle pulse on forced release
//   timeout_id     index of the last timed-out child
module root_child_arbiter #(
  parameter  int NUM_CHILD = 5,
  parameter  int TIMEOUT   = 16,
  localparam int IDW       = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CHILD-1:0] req,
  input  logic [NUM_CHILD-1:0] done,
  output logic [NUM_CHILD-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_pulse,
  output logic [IDW-1:0]       timeout_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;

  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;
  logic           sel_vld;
  logic           done_g;

  // Rotating priority search starting at ptr. Walk offsets from the far end
  // back towards ptr so the nearest set request is the last one written.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = NUM_CHILD - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NUM_CHILD);
      if (req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // grant is one-hot on the owner, so masking done with it ignores every
  // other child's completion bit.
  assign done_g = |(done & grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_id    <= '0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state    <= GRANT;
            grant    <= NUM_CHILD'(1) << sel;
            grant_id <= sel;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        GRANT: begin
          // done has priority over the watchdog on the boundary cycle.
          if (done_g || cnt == CW'(TIMEOUT - 1)) begin
            state <= RELEASE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= (grant_id == IDW'(NUM_CHILD - 1)) ? '0 : grant_id + 1'b1;
            if (!done_g) begin
              timeout_pulse <= 1'b1;
              timeout_id    <= grant_id;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
